// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared definitions for the write-back select stage.
//                Holds the load-size encodings and the default source
//                indices of the write-back mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Load-size encodings; both 2'b10 and 2'b11 mean a full word
  localparam logic [1:0] LSZ_BYTE = 2'b00;
  localparam logic [1:0] LSZ_HALF = 2'b01;
  localparam logic [1:0] LSZ_WORD = 2'b10;

  // Default source indices of the write-back mux
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_IMM = 1;
  localparam int WB_SRC_MEM = 2;
  localparam int WB_SRC_PC  = 3;

endpackage
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_ext
//  Description : Combinational sub-word load lane extraction, sign/zero
//                extension and misalignment detection. Lanes are taken from
//                the low 32 bits of the load word, so DW must be >= 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rawData,
  input  logic [1:0]    i_lsize,
  input  logic          i_lunsigned,
  input  logic [1:0]    i_addrLo,
  output logic [DW-1:0] o_extData,
  output logic          o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, extend it, and flag accesses that straddle lanes
  always_comb begin
    w_byte     = i_rawData[{i_addrLo, 3'b000} +: 8];
    w_half     = i_rawData[{i_addrLo[1], 4'b0000} +: 16];
    o_extData  = i_rawData;
    o_misalign = 1'b0;
    case (i_lsize)
      LSZ_BYTE: begin
        o_extData = {{(DW-8){w_byte[7] & ~i_lunsigned}}, w_byte};
      end
      LSZ_HALF: begin
        o_extData  = {{(DW-16){w_half[15] & ~i_lunsigned}}, w_half};
        o_misalign = i_addrLo[0];
      end
      default: begin
        o_misalign = (i_addrLo != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_stage
//  Description : Registered write-back source selector at the MA/WB boundary
//                with stall, flush and r0 write suppression. Optional load
//                extraction is enabled by defining WB_LOAD_EXT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NSRC     = 4,
  parameter int SELW     = $clog2(NSRC),
  parameter int RW       = 5,
  parameter int LOAD_SRC = WB_SRC_MEM
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC*DW-1:0] src_data_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic [RW-1:0]      rd_i,
  input  logic               we_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [1:0]         lsize_i,
  input  logic               lunsigned_i,
  input  logic [1:0]         addr_lo_i,
  output logic [DW-1:0]      wb_data_o,
  output logic [RW-1:0]      wb_rd_o,
  output logic               wb_we_o,
  output logic               wb_valid_o,
  output logic               misalign_o
);

  logic [DW-1:0] w_selData;
  logic [DW-1:0] w_resData;
  logic          w_misalign;
  logic          w_weEff;

  logic [DW-1:0] r_wbData;
  logic [RW-1:0] r_wbRd;
  logic          r_wbWe;
  logic          r_wbValid;
  logic          r_misalign;

  // Source mux; out-of-range selects fall through to the last source
  always_comb begin
    w_selData = src_data_i[(NSRC-1)*DW +: DW];
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SELW'(k)) begin
        w_selData = src_data_i[k*DW +: DW];
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [DW-1:0] w_extData;
  logic          w_extMisalign;
  logic          w_isLoad;

  assign w_isLoad = (sel_i == SELW'(LOAD_SRC));

  wb_load_ext #(
    .DW (DW)
  ) u_loadExt (
    .i_rawData   (w_selData),
    .i_lsize     (lsize_i),
    .i_lunsigned (lunsigned_i),
    .i_addrLo    (addr_lo_i),
    .o_extData   (w_extData),
    .o_misalign  (w_extMisalign)
  );

  assign w_resData  = w_isLoad ? w_extData : w_selData;
  assign w_misalign = w_isLoad & w_extMisalign;
`else
  // Load-shaping inputs have no function without the extraction path
  logic w_unusedLoadBits;
  assign w_unusedLoadBits = ^{lsize_i, lunsigned_i, addr_lo_i};

  assign w_resData  = w_selData;
  assign w_misalign = 1'b0;
`endif

  assign w_weEff = valid_i & we_i & (rd_i != '0) & ~w_misalign;

  // Stage register: flush kills control bits, stall holds, otherwise capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbData   <= '0;
      r_wbRd     <= '0;
      r_wbWe     <= 1'b0;
      r_wbValid  <= 1'b0;
      r_misalign <= 1'b0;
    end else if (flush_i) begin
      r_wbWe     <= 1'b0;
      r_wbValid  <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!stall_i) begin
      r_wbData   <= w_resData;
      r_wbRd     <= rd_i;
      r_wbWe     <= w_weEff;
      r_wbValid  <= valid_i;
      r_misalign <= valid_i & w_misalign;
    end
  end

  assign wb_data_o  = r_wbData;
  assign wb_rd_o    = r_wbRd;
  assign wb_we_o    = r_wbWe;
  assign wb_valid_o = r_wbValid;
  assign misalign_o = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_select_stage
//  Description : Scoreboard bench for wb_select_stage. A driver applies
//                directed vectors and queues their expected outputs; a
//                monitor pops and compares after each capturing edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        valid;
    logic        mis;
    logic [31:0] d3;
  } exp_t;

  exp_t expQ[$];
  int   nVec  = 0;
  int   nFail = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] srcs;
  logic [1:0]   sel;
  logic [4:0]   rd;
  logic         we, valid, stall, flush, lunsigned;
  logic [1:0]   lsize, addrLo;

  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        wbWe, wbValid, misalign;

  logic [31:0] d3Data;
  logic [4:0]  unused3Rd;
  logic        unused3We, unused3Valid, unused3Mis;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data_i  (srcs),
    .sel_i       (sel),
    .rd_i        (rd),
    .we_i        (we),
    .valid_i     (valid),
    .stall_i     (stall),
    .flush_i     (flush),
    .lsize_i     (lsize),
    .lunsigned_i (lunsigned),
    .addr_lo_i   (addrLo),
    .wb_data_o   (wbData),
    .wb_rd_o     (wbRd),
    .wb_we_o     (wbWe),
    .wb_valid_o  (wbValid),
    .misalign_o  (misalign)
  );

  // Three-source instance: select 3 is out of range and must pick source 2
  wb_select_stage #(.NSRC(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data_i  (srcs[95:0]),
    .sel_i       (sel),
    .rd_i        (5'd1),
    .we_i        (1'b1),
    .valid_i     (1'b1),
    .stall_i     (1'b0),
    .flush_i     (1'b0),
    .lsize_i     (WORD),
    .lunsigned_i (1'b0),
    .addr_lo_i   (2'b00),
    .wb_data_o   (d3Data),
    .wb_rd_o     (unused3Rd),
    .wb_we_o     (unused3We),
    .wb_valid_o  (unused3Valid),
    .misalign_o  (unused3Mis)
  );

  // Monitor: compare the head of the scoreboard after every capturing edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nVec++;
        if (wbData !== e.data || wbRd !== e.rd || wbWe !== e.we ||
            wbValid !== e.valid || misalign !== e.mis || d3Data !== e.d3) begin
          nFail++;
          $display("FAIL %s: got data=%h rd=%0d we=%b valid=%b mis=%b d3=%h, want data=%h rd=%0d we=%b valid=%b mis=%b d3=%h",
                   e.name, wbData, wbRd, wbWe, wbValid, misalign, d3Data,
                   e.data, e.rd, e.we, e.valid, e.mis, e.d3);
        end
      end
    end
  end

  task automatic vec(input string nm, input logic [1:0] s, input logic [4:0] r,
                     input logic w, input logic v, input logic st, input logic fl,
                     input logic [1:0] lsz, input logic lu, input logic [1:0] alo,
                     input logic [31:0] eData, input logic [4:0] eRd,
                     input logic eWe, input logic eValid, input logic eMis);
    exp_t e;
    @(negedge clk);
    sel = s; rd = r; we = w; valid = v; stall = st; flush = fl;
    lsize = lsz; lunsigned = lu; addrLo = alo;
    e.name = nm; e.data = eData; e.rd = eRd; e.we = eWe; e.valid = eValid; e.mis = eMis;
    case (s)
      2'd0:    e.d3 = srcs[31:0];
      2'd1:    e.d3 = srcs[63:32];
      default: e.d3 = srcs[95:64];
    endcase
    expQ.push_back(e);
  endtask

  task automatic checkReset(input string nm);
    nVec++;
    if (wbData !== 32'h0 || wbRd !== 5'd0 || wbWe !== 1'b0 || wbValid !== 1'b0 ||
        misalign !== 1'b0 || d3Data !== 32'h0) begin
      nFail++;
      $display("FAIL %s: got data=%h rd=%0d we=%b valid=%b mis=%b d3=%h, want all zero",
               nm, wbData, wbRd, wbWe, wbValid, misalign, d3Data);
    end
  endtask

  initial begin
    srcs = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel = 2'd0; rd = 5'd0; we = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    lsize = WORD; lunsigned = 1'b0; addrLo = 2'b00;

    repeat (2) @(negedge clk);
    checkReset("reset_init");
    rst_n = 1'b1;

    // Select sweep; sel=3 on the three-source instance picks source 2
    vec("sel0", 2'd0, 5'd1, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h11111111, 5'd1, 1, 1, 0);
    vec("sel1", 2'd1, 5'd2, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h22222222, 5'd2, 1, 1, 0);
    vec("sel2", 2'd2, 5'd3, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h33333333, 5'd3, 1, 1, 0);
    vec("sel3", 2'd3, 5'd4, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h44444444, 5'd4, 1, 1, 0);
    vec("rd0_we", 2'd0, 5'd0, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h11111111, 5'd0, 0, 1, 0);
    vec("not_valid", 2'd1, 5'd5, 1, 0, 0, 0, WORD, 0, 2'd0, 32'h22222222, 5'd5, 0, 0, 0);

    // Load extraction on the memory source
    @(negedge clk);
    srcs[95:64] = 32'h80FF7F01;
    expQ.push_back('{name: "hold_idle", data: 32'h22222222, rd: 5'd5, we: 1'b0,
                     valid: 1'b0, mis: 1'b0, d3: 32'h22222222});
    vec("ld_b1_s", 2'd2, 5'd6, 1, 1, 0, 0, BYTE, 0, 2'd1,
        EXT ? 32'h0000007F : 32'h80FF7F01, 5'd6, 1, 1, 0);
    vec("ld_b2_s", 2'd2, 5'd6, 1, 1, 0, 0, BYTE, 0, 2'd2,
        EXT ? 32'hFFFFFFFF : 32'h80FF7F01, 5'd6, 1, 1, 0);
    vec("ld_h2_u", 2'd2, 5'd6, 1, 1, 0, 0, HALF, 1, 2'd2,
        EXT ? 32'h000080FF : 32'h80FF7F01, 5'd6, 1, 1, 0);
    vec("ld_w2_mis", 2'd2, 5'd7, 1, 1, 0, 0, WORD, 0, 2'd2,
        32'h80FF7F01, 5'd7, !EXT, 1, EXT);
    vec("ld_b3_u", 2'd2, 5'd6, 1, 1, 0, 0, BYTE, 1, 2'd3,
        EXT ? 32'h00000080 : 32'h80FF7F01, 5'd6, 1, 1, 0);
    vec("ld_h1_mis", 2'd2, 5'd6, 1, 1, 0, 0, HALF, 0, 2'd1,
        EXT ? 32'h00007F01 : 32'h80FF7F01, 5'd6, !EXT, 1, EXT);

    // Three-cycle stall freezes outputs, next instruction captured after
    vec("pre_stall", 2'd0, 5'd8, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h11111111, 5'd8, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      vec("stall", 2'd3, 5'd9, 1, 1, 1, 0, WORD, 0, 2'd0, 32'h11111111, 5'd8, 1, 1, 0);
    vec("post_stall", 2'd3, 5'd9, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h44444444, 5'd9, 1, 1, 0);

    // Flush beats stall; data and rd keep their old values
    vec("flush_stall", 2'd1, 5'd10, 1, 1, 1, 1, WORD, 0, 2'd0, 32'h44444444, 5'd9, 0, 0, 0);
    vec("post_flush", 2'd1, 5'd10, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h22222222, 5'd10, 1, 1, 0);
    vec("mis_again", 2'd2, 5'd11, 1, 1, 0, 0, WORD, 0, 2'd2, 32'h80FF7F01, 5'd11, !EXT, 1, EXT);
    vec("flush_mis", 2'd0, 5'd12, 1, 1, 0, 1, WORD, 0, 2'd0, 32'h80FF7F01, 5'd11, 0, 0, 0);

    // Asynchronous reset in the middle of a stall, between clock edges
    vec("pre_reset", 2'd0, 5'd3, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h11111111, 5'd3, 1, 1, 0);
    vec("stall_hold", 2'd1, 5'd4, 1, 1, 1, 0, WORD, 0, 2'd0, 32'h11111111, 5'd3, 1, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("reset_mid_stall");
    @(negedge clk);
    rst_n = 1'b1;
    vec("after_reset", 2'd1, 5'd4, 1, 1, 0, 0, WORD, 0, 2'd0, 32'h22222222, 5'd4, 1, 1, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      nVec++;
      nFail++;
      $display("FAIL drain: got %0d pending entries, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised write-back selector for the pipeline's MA/WB boundary. Chooses one of `NSRC` result sources per instruction, optionally extracts and extends sub-word load data, and registers the selected value with its destination register, write enable and valid flag. This adds stall and flush control and r0 write suppression. Its registered outputs drive both the register-file write port and the forwarding network.

## Interface
Parameters:
- `DW`, 32, data width of each source and of the result.
- `NSRC`, 4, number of sources; must be ≥ 2.
- `SELW`, `$clog2(NSRC)`, select width (derived; do not override).
- `RW`, 5, register-address width.
- `LOAD_SRC`, 2, index of the source carrying raw memory load data.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `src_data_i` in `NSRC*DW`: packed sources; source k occupies bits `[k*DW +: DW]`.
- `sel_i` in `SELW`: source select.
- `rd_i` in `RW`: destination register.
- `we_i` in 1: register write request.
- `valid_i` in 1: input instruction valid.
- `stall_i` in 1: hold stage contents.
- `flush_i` in 1: kill stage contents.
- `lsize_i` in 2: load size; 00 byte, 01 half, 10/11 word.
- `lunsigned_i` in 1: zero-extend instead of sign-extend.
- `addr_lo_i` in 2: low address bits of the load.
- `wb_data_o` out `DW`: registered write-back data.
- `wb_rd_o` out `RW`: registered destination.
- `wb_we_o` out 1: registered effective write enable.
- `wb_valid_o` out 1: registered valid.
- `misalign_o` out 1: registered misaligned-load flag.

## Operation
- Source select: `sel_i < NSRC` picks source `sel_i`. Any larger value picks source `NSRC-1`, mirroring the last-branch default of the earlier mux.
- Load extraction: applies only when `sel_i == LOAD_SRC`.
  - Byte: lane `addr_lo_i`.
  - Half: lane `addr_lo_i[1]`.
  - Word: unchanged.
  - Byte and half results are extended to `DW` per `lunsigned_i`.
- Misaligned load: half with `addr_lo_i[0]=1`, or word with `addr_lo_i!=0`.
  - Data is still passed, using the lane rules above.
  - `misalign_o=1` on that instruction's output cycle.
  - `wb_we_o` is forced to 0.
- Effective write enable: `we_eff = valid_i & we_i & (rd_i != 0) & ~misalign`.
- Register update each cycle, in priority order:
  1. `flush_i`: `wb_valid_o`, `wb_we_o` and `misalign_o` go to 0. Data and rd keep their old values. Flush beats stall.
  2. `stall_i`: all outputs hold.
  3. Otherwise: all outputs load from the inputs. With `valid_i=0`, valid, we and misalign load 0 and data/rd are still captured.

## Timing
- Latency: exactly 1 cycle from input to outputs. No combinational path from inputs to outputs.
- Reset: every output is 0 (`wb_data_o=0`, `wb_rd_o=0`, `wb_we_o=0`, `wb_valid_o=0`, `misalign_o=0`).
  - Assertion clears outputs immediately, mid-stall included.
  - First capture happens on the first rising edge after `rst_n` is high.
- `stall_i` held for N cycles: outputs are stable for N cycles. The instruction presented at the edge after stall drops is captured.
- `flush_i` and `stall_i` together: flush result, valid 0.

## Configuration
- `WB_LOAD_EXT_EN` defined: load extraction, extension and misalign detection work as described.
- Undefined:
  - `LOAD_SRC` is treated like any other source, passing full width.
  - `lsize_i`, `lunsigned_i` and `addr_lo_i` are ignored.
  - `misalign_o` is tied to 0.
  - `we_eff` omits the misalign term.

## Structure
- Shared package `wb_pkg` holds:
  - Load-size encodings `LSZ_BYTE`, `LSZ_HALF`, `LSZ_WORD`.
  - Default source indices `WB_SRC_ALU=0`, `WB_SRC_IMM=1`, `WB_SRC_MEM=2`, `WB_SRC_PC=3`.
- One sub-module, `wb_load_ext`: purely combinational lane extraction, extension and misalign detection. It is instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- Reset mid-stream: assert `rst_n=0` with `wb_valid_o=1` → all outputs 0 with no clock edge. After release, first capture has the expected data.
- Select sweep: sources 0x11111111..0x44444444, `sel` 0..3 → `wb_data_o` equals the matching source one cycle later.
- Default select: `NSRC=3`, `sel=3` → source 2 selected.
- Load extraction, `sel=LOAD_SRC`, data 0x80FF7F01:
  - byte, `addr_lo=1`, signed → 0x0000007F.
  - byte, `addr_lo=2`, signed → 0xFFFFFFFF.
  - half, `addr_lo=2`, unsigned → 0x000080FF.
- Misaligned word at `addr_lo=2` with `we=1` → `misalign_o=1`, `wb_we_o=0`. Define-off build → `misalign_o=0`, `wb_we_o=1`, data 0x80FF7F01.
- Control:
  - `rd=0`, `we=1` → `wb_we_o=0`.
  - 3-cycle stall → outputs frozen.
  - flush+stall same cycle → `wb_valid_o=0`, `wb_we_o=0` next cycle.
